reg_serial_reader: RTL and testbench
====================================

Name: reg_serial_reader

Overview:
- Parallel-in, serial-out reader for a multi-bit register.
- Captures a WIDTH-bit register word on a load strobe and presents it one bit per accepted transfer on a valid/ready serial interface.
- Sits on the read side of the register bank and feeds bit-serial consumers (serial ALU paths, debug scan-out).
- Signals completion with a one-cycle done pulse.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32
MSB_FIRST, 0, 0 = bit 0 shifted out first; 1 = bit WIDTH-1 shifted out first

Ports:
C  input  1  clock; all state changes on rising edge
nR  input  1  synchronous active-low reset, sampled on rising edge of C
D  input  WIDTH  parallel register word to be read out
L  input  1  load strobe; sampled only in IDLE
RDY  input  1  sink ready; a bit is accepted on an edge where V=1 and RDY=1
Q  output  1  current serial bit
V  output  1  Q holds a valid bit
B  output  1  busy: high in SHIFT and DONE
DN  output  1  done pulse, high for exactly one cycle after the last bit is accepted

Behaviour:
- Reset
  - nR=0 at a rising edge forces state IDLE, shift register=0, bit counter=0.
  - Outputs during reset: Q=0, V=0, B=0, DN=0.
  - Reset has priority over L and RDY in every state, including mid-transfer. A partial word is discarded, and no DN pulse is produced.
- Internal state
  - Shift register SR[WIDTH-1:0].
  - Bit counter CNT, width max(1, ceil(log2(WIDTH))).
  - States: IDLE, SHIFT, DONE.
- IDLE
  - Outputs: V=0, B=0, DN=0, Q=0.
  - L=1 at an edge: SR<=D, CNT<=0, state SHIFT.
  - L=0: remain in IDLE. D is ignored.
- SHIFT
  - Outputs: V=1, B=1, DN=0.
  - Q=SR[0] when MSB_FIRST=0; Q=SR[WIDTH-1] when MSB_FIRST=1.
  - Edge with RDY=0: SR, CNT and Q hold. The sink may stall indefinitely.
  - Edge with RDY=1 and CNT<WIDTH-1: SR shifts by one toward the output end, with 0 filled in at the vacated end, and CNT<=CNT+1.
  - Edge with RDY=1 and CNT=WIDTH-1: state DONE; SR and CNT are don't-care afterwards.
  - L and D are ignored in SHIFT, and a new load never corrupts a transfer in progress.
- DONE
  - Outputs: V=0, B=1, DN=1, Q=0.
  - Next edge goes unconditionally to IDLE.
  - L is ignored in DONE; the producer must present L in IDLE.
  - Minimum spacing between back-to-back loads: WIDTH+2 cycles.
- Latency, with RDY held at 1
  - L sampled at edge k.
  - First bit valid in the cycle after edge k.
  - Bit i accepted at edge k+1+i.
  - DN high in the cycle after edge k+WIDTH.
  - B low again after edge k+WIDTH+1.
- Ordering and integrity
  - Exactly WIDTH bits are accepted per load, each exactly once, in the configured order.
  - Q changes only on an accepting edge or on a state change.
- All outputs are registered or derived only from state and SR; there is no combinational path from RDY or L to any output.

Test Plan:
- Reset mid-transfer (WIDTH=8): load 8'hA5, accept 3 bits, drive nR=0 for one edge.
  -> Q=V=B=DN=0 on the next cycle, state IDLE, no DN pulse.
  -> A subsequent load of 8'h3C reads out 0,0,1,1,1,1,0,0 (LSB first).
- Basic LSB-first read (MSB_FIRST=0): D=8'hA5, L pulse, RDY=1.
  -> Q sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles with V=1.
  -> DN=1 for exactly one cycle after the 8th bit, then B=0.
- MSB-first read (MSB_FIRST=1): D=8'hA5, RDY=1.
  -> Q sequence 1,0,1,0,0,1,0,1 read as bits 7..0 of 8'hA5 (1010_0101).
  -> Repeat with D=8'h01: expect 0,0,0,0,0,0,0,1.
- Stall: D=8'hF0, RDY low for 5 cycles after the 2nd bit.
  -> Q=0 and V=1 held stable through the stall, CNT unchanged.
  -> Remaining bits 0,0,1,1,1,1 follow once RDY=1; total 8 accepted bits.
- Ignored loads: assert L continuously with D toggling during SHIFT and DONE.
  -> The captured word is unchanged.
  -> A new capture occurs only on the first edge in IDLE, giving a back-to-back period of exactly WIDTH+2 = 10 cycles.
- Boundary (WIDTH=2): D=2'b10, RDY=1.
  -> Q=0 then 1, DN one cycle later, IDLE after 4 cycles.
  -> CNT wraps correctly with the 1-bit counter.

Source files
------------

// File: rtl/reg_serial_reader.sv
// Parallel-in, serial-out register reader: captures a WIDTH-bit word on L and
// streams it one bit per accepted valid/ready transfer, then pulses DN.
module reg_serial_reader #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             C,
    input  logic             nR,
    input  logic [WIDTH-1:0] D,
    input  logic             L,
    input  logic             RDY,
    output logic             Q,
    output logic             V,
    output logic             B,
    output logic             DN
);

    localparam int unsigned CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] sr_shift;
    logic             load_bit;
    logic             next_bit;

    // Shift toward the output end with zero fill; pick the bit that lands there.
    always_comb begin
        sr_shift = '0;
        load_bit = 1'b0;
        next_bit = 1'b0;
        if (MSB_FIRST) begin
            sr_shift = {sr[WIDTH-2:0], 1'b0};
            load_bit = D[WIDTH-1];
            next_bit = sr[WIDTH-2];
        end else begin
            sr_shift = {1'b0, sr[WIDTH-1:1]};
            load_bit = D[0];
            next_bit = sr[1];
        end
    end

    // FSM with registered outputs; reset wins over every other input.
    always_ff @(posedge C) begin
        if (!nR) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            Q     <= 1'b0;
            V     <= 1'b0;
            B     <= 1'b0;
            DN    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (L) begin
                        state <= SHIFT;
                        sr    <= D;
                        cnt   <= '0;
                        Q     <= load_bit;
                        V     <= 1'b1;
                        B     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (RDY) begin
                        if (cnt == LAST) begin
                            state <= DONE;
                            Q     <= 1'b0;
                            V     <= 1'b0;
                            DN    <= 1'b1;
                        end else begin
                            sr  <= sr_shift;
                            cnt <= cnt + CW'(1);
                            Q   <= next_bit;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    B     <= 1'b0;
                    DN    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Q     <= 1'b0;
                    V     <= 1'b0;
                    B     <= 1'b0;
                    DN    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_serial_reader.sv
// Bench for reg_serial_reader: three configurations (8/LSB, 8/MSB, 2/LSB) share
// stimulus and are checked every cycle against a transfer-level model.
module tb_reg_serial_reader;

    logic       C = 1'b0;
    logic       nR;
    logic [7:0] D8;
    logic       L;
    logic       RDY;
    logic [2:0] q, v, b, dn;

    int n_tot  = 0;
    int n_pass = 0;

    reg_serial_reader #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
        .C(C), .nR(nR), .D(D8), .L(L), .RDY(RDY),
        .Q(q[0]), .V(v[0]), .B(b[0]), .DN(dn[0]));
    reg_serial_reader #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
        .C(C), .nR(nR), .D(D8), .L(L), .RDY(RDY),
        .Q(q[1]), .V(v[1]), .B(b[1]), .DN(dn[1]));
    reg_serial_reader #(.WIDTH(2), .MSB_FIRST(1'b0)) u_w2 (
        .C(C), .nR(nR), .D(D8[1:0]), .L(L), .RDY(RDY),
        .Q(q[2]), .V(v[2]), .B(b[2]), .DN(dn[2]));

    always #5 C = ~C;

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s inst%0d actual=%0d required=%0d t=%0t", nm, inst, act, exp, $time);
    endtask

    // Model: a word with a count of bits still owed, plus a done flag.
    int unsigned mw[3] = '{8, 8, 2};
    bit          mm[3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] m_word[3];
    int          m_left[3] = '{0, 0, 0};
    bit          m_done[3] = '{0, 0, 0};
    bit          started = 1'b0;

    function automatic int exp_q(input int i);
        int k;
        int idx;
        if (m_left[i] == 0) return 0;
        k   = int'(mw[i]) - m_left[i];
        idx = mm[i] ? int'(mw[i]) - 1 - k : k;
        return int'(m_word[i][idx]);
    endfunction

    always @(posedge C) begin
        started <= 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!nR) begin
                m_left[i] <= 0;
                m_done[i] <= 1'b0;
            end else if (m_done[i]) begin
                m_done[i] <= 1'b0;
            end else if (m_left[i] > 0) begin
                if (RDY) begin
                    if (m_left[i] == 1) m_done[i] <= 1'b1;
                    m_left[i] <= m_left[i] - 1;
                end
            end else if (L) begin
                m_word[i] <= 32'(D8) & ((32'h1 << mw[i]) - 32'h1);
                m_left[i] <= int'(mw[i]);
            end
        end
    end

    always @(negedge C) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk("model_q",  i, int'(q[i]),  exp_q(i));
                chk("model_v",  i, int'(v[i]),  int'(m_left[i] > 0));
                chk("model_b",  i, int'(b[i]),  int'(m_left[i] > 0 || m_done[i]));
                chk("model_dn", i, int'(dn[i]), int'(m_done[i]));
            end
        end
    end

    task automatic settle(input int n);
        L   = 1'b0;
        RDY = 1'b1;
        repeat (n) @(negedge C);
    endtask

    task automatic load(input logic [7:0] val);
        D8 = val;
        L  = 1'b1;
        @(negedge C);
        L  = 1'b0;
    endtask

    initial begin
        logic [7:0] seq_a, seq_b;
        int rise0[$];
        int rise2[$];
        logic pv0, pv2;

        nR = 1'b0; L = 1'b0; RDY = 1'b0; D8 = 8'h00;
        repeat (2) @(negedge C);
        for (int i = 0; i < 3; i++) begin
            chk("rst_q", i, int'(q[i]), 0);
            chk("rst_v", i, int'(v[i]), 0);
            chk("rst_b", i, int'(b[i]), 0);
            chk("rst_dn", i, int'(dn[i]), 0);
        end
        nR = 1'b1;
        settle(2);

        // Basic read of A5; the MSB-first order happens to give the same sequence.
        seq_a = 8'b1010_0101;
        load(8'hA5);
        for (int i = 0; i < 8; i++) begin
            chk("a5_lsb_q", 0, int'(q[0]), int'(seq_a[7-i]));
            chk("a5_msb_q", 1, int'(q[1]), int'(seq_a[7-i]));
            chk("a5_v", 0, int'(v[0]), 1);
            @(negedge C);
        end
        chk("a5_dn", 0, int'(dn[0]), 1);
        chk("a5_dn_b", 0, int'(b[0]), 1);
        @(negedge C);
        chk("a5_dn_off", 0, int'(dn[0]), 0);
        chk("a5_b_off", 0, int'(b[0]), 0);
        settle(3);

        // 8'h01 in both orders.
        seq_a = 8'b1000_0000;
        seq_b = 8'b0000_0001;
        load(8'h01);
        for (int i = 0; i < 8; i++) begin
            chk("h01_lsb_q", 0, int'(q[0]), int'(seq_a[7-i]));
            chk("h01_msb_q", 1, int'(q[1]), int'(seq_b[7-i]));
            @(negedge C);
        end
        settle(3);

        // Reset after three accepted bits, then a clean reload.
        load(8'hA5);
        repeat (3) @(negedge C);
        nR = 1'b0;
        @(negedge C);
        chk("midrst_q", 0, int'(q[0]), 0);
        chk("midrst_v", 0, int'(v[0]), 0);
        chk("midrst_b", 0, int'(b[0]), 0);
        chk("midrst_dn", 0, int'(dn[0]), 0);
        nR = 1'b1;
        seq_a = 8'b0011_1100;
        load(8'h3C);
        for (int i = 0; i < 8; i++) begin
            chk("h3c_q", 0, int'(q[0]), int'(seq_a[7-i]));
            @(negedge C);
        end
        chk("h3c_dn", 0, int'(dn[0]), 1);
        settle(3);

        // Stall after two accepted bits of F0.
        seq_a = 8'b0000_1111;
        load(8'hF0);
        chk("stall_b0", 0, int'(q[0]), 0);
        @(negedge C);
        chk("stall_b1", 0, int'(q[0]), 0);
        @(negedge C);
        RDY = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge C);
            chk("stall_hold_q", 0, int'(q[0]), 0);
            chk("stall_hold_v", 0, int'(v[0]), 1);
        end
        RDY = 1'b1;
        for (int i = 2; i < 8; i++) begin
            chk("stall_rest_q", 0, int'(q[0]), int'(seq_a[7-i]));
            @(negedge C);
        end
        chk("stall_dn", 0, int'(dn[0]), 1);
        settle(3);

        // Continuous L with D churning: reload period is WIDTH+2.
        pv0 = v[0];
        pv2 = v[2];
        L = 1'b1;
        for (int c = 0; c < 30; c++) begin
            D8 = 8'($urandom);
            @(negedge C);
            if (v[0] && !pv0) rise0.push_back(c);
            if (v[2] && !pv2) rise2.push_back(c);
            pv0 = v[0];
            pv2 = v[2];
        end
        L = 1'b0;
        chk("period_rises8", 0, int'(rise0.size() >= 2), 1);
        chk("period_rises2", 2, int'(rise2.size() >= 2), 1);
        if (rise0.size() >= 2) chk("period8", 0, rise0[1] - rise0[0], 10);
        if (rise2.size() >= 2) chk("period2", 2, rise2[1] - rise2[0], 4);
        settle(12);

        // WIDTH=2 boundary with 2'b10.
        load(8'h02);
        chk("w2_b0", 2, int'(q[2]), 0);
        chk("w2_v", 2, int'(v[2]), 1);
        @(negedge C);
        chk("w2_b1", 2, int'(q[2]), 1);
        @(negedge C);
        chk("w2_dn", 2, int'(dn[2]), 1);
        chk("w2_dn_v", 2, int'(v[2]), 0);
        chk("w2_dn_b", 2, int'(b[2]), 1);
        @(negedge C);
        chk("w2_idle_b", 2, int'(b[2]), 0);
        chk("w2_idle_dn", 2, int'(dn[2]), 0);
        settle(12);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            nR  = ($urandom_range(63) != 0);
            L   = ($urandom_range(2) == 0);
            RDY = ($urandom_range(1) == 0);
            D8  = 8'($urandom);
            @(negedge C);
        end
        nR = 1'b1;
        settle(12);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
